cpu_mem_responder: RTL



---
 rtl/cpu_mem_pkg.sv | 12 +
 rtl/mem_read_port.sv | 44 ++++
 rtl/cpu_mem_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
// Imported by the top level and by the read-port pipeline.
package cpu_mem_pkg;
    localparam int WORD_W     = 16;
    localparam int DEF_ADDR_W = 15;
    localparam int RD_LAT     = 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;
endpackage

// File: rtl/mem_read_port.sv
// Two-stage read response pipeline for one CPU read port.
// A store in the request cycle to the same word overrides the array output.
module mem_read_port
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] mem_q,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WORD_W-1:0] w_data,
    output logic              rvalid,
    output logic [WORD_W-1:0] rdata
);
    logic [RD_LAT-1:0] vld_reg;
    logic              byp_reg;
    logic [WORD_W-1:0] byp_data_reg;
    logic [WORD_W-1:0] rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg      <= '0;
            byp_reg      <= 1'b0;
            byp_data_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            vld_reg      <= {vld_reg[RD_LAT-2:0], req && en};
            // The array read registered alongside still holds the pre-store word.
            byp_reg      <= w_en && (w_addr == addr);
            byp_data_reg <= w_data;
            if (vld_reg[0]) begin
                rdata_reg <= byp_reg ? byp_data_reg : mem_q;
            end
        end
    end

    assign rvalid = vld_reg[RD_LAT-1];
    assign rdata  = rdata_reg;
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: clears the array after reset, then serves a fetch
// port and a load port (2-cycle latency) plus one store port every cycle.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INIT_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WORD_W-1:0] w_data,
    output logic              err_drop
);
    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(INIT_WORDS - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              clr;
    logic              st_en;
    logic              err_reg;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clr        = 1'b0;
        case (state_reg)
            ST_INIT: begin
                clr      = 1'b1;
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == LAST_PTR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign ready = (state_reg == ST_RUN);
    assign st_en = ready && w_en;

    // Clear and store are mutually exclusive: stores are dropped while clearing.
    assign wr_addr = clr ? ptr_reg : w_addr;
    assign wr_data = clr ? '0 : w_data;

    always_ff @(posedge clk) begin
        if (clr || st_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (!ready && (f_req || d_req || w_en)) begin
            err_reg <= 1'b1;
        end
    end
    assign err_drop = err_reg;

    // Port 0 is fetch, port 1 is load; each gets its own registered array read.
    logic [1:0]        p_req;
    logic [1:0]        p_rvalid;
    logic [ADDR_W-1:0] p_addr  [2];
    logic [WORD_W-1:0] p_rdata [2];

    assign p_req     = {d_req, f_req};
    assign p_addr[0] = f_addr;
    assign p_addr[1] = d_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WORD_W-1:0] mem_q_reg;

            always_ff @(posedge clk) begin
                mem_q_reg <= mem[p_addr[gi]];
            end

            mem_read_port #(.ADDR_W(ADDR_W)) u_port (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (ready),
                .req    (p_req[gi]),
                .addr   (p_addr[gi]),
                .mem_q  (mem_q_reg),
                .w_en   (st_en),
                .w_addr (w_addr),
                .w_data (w_data),
                .rvalid (p_rvalid[gi]),
                .rdata  (p_rdata[gi])
            );
        end
    endgenerate

    assign f_rvalid = p_rvalid[0];
    assign f_rdata  = p_rdata[0];
    assign d_rvalid = p_rvalid[1];
    assign d_rdata  = p_rdata[1];
endmodule
